memory_access_stage: RTL and testbench
======================================

# memory_access_stage

Pipeline stage directly downstream of the execution stage: consumes the registered ALU result, store data and memory-control bits, performs one data-memory access per load/store over a req/ack bus, aligns and extends load data, and registers the writeback result. It stalls the upstream stages while a bus transaction is outstanding. Its outputs feed the register-file writeback port.

## Interface
- TIMEOUT_CYCLES, 16: BUSY cycles without ack before abort. Used only with MEM_TIMEOUT_EN; range 2–255.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ans_ex  in  32  ALU result; this is the memory byte address for loads and stores.
- B_Bypass  in  32  store data, already zero-extended to the access size upstream.
- dm_en_in  in  1  1 = load or store.
- dm_rw_in  in  1  0 = read, 1 = write.
- seldmresult_in  in  1  1 = writeback takes load data, 0 = writeback takes ans_ex.
- rw_in  in  5  destination register.
- enloadsize  in  2  bit 1 set = word; bit 0 set = halfword; neither = byte.
- loadsign  in  1  1 = sign-extend sub-word loads.
- stall  out  1  freeze upstream pipeline registers.
- dmem_req  out  1  bus request.
- dmem_we  out  1  bus write.
- dmem_addr  out  32  word-aligned address, {ans_ex[31:2],2'b00}.
- dmem_wdata  out  32  store data replicated across byte lanes.
- dmem_wstrb  out  4  byte-lane strobes.
- dmem_ack  in  1  transaction complete; dmem_rdata is valid in the same cycle.
- dmem_rdata  in  32  read data.
- wb_data  out  32  writeback value.
- wb_rw  out  5  writeback destination register.
- wb_valid  out  1  writeback enable.
- misalign  out  1  one-cycle pulse for a misaligned access.
- mem_fault  out  1  one-cycle pulse for a bus timeout.

## Operation
- States: IDLE, BUSY.
- IDLE, dm_en_in=0: register wb_data=ans_ex, wb_rw=rw_in, wb_valid=1. No bus activity.
- IDLE, dm_en_in=1, aligned: latch the request, assert dmem_req and set dmem_we=dm_rw_in, then go to BUSY. Bus outputs are registered.
- Alignment rules:
  - Word access is misaligned if ans_ex[1:0]≠0.
  - Halfword access is misaligned if ans_ex[0]=1.
  - Byte access is always aligned.
- IDLE, dm_en_in=1, misaligned: no request is issued. Pulse misalign, wb_valid=0, stay in IDLE.
- Store strobes:
  - Byte: wstrb = 0001<<addr[1:0], wdata = {4{B[7:0]}}.
  - Halfword: wstrb = 0011<<addr[1:0], wdata = {2{B[15:0]}}.
  - Word: wstrb = 1111, wdata = B.
- Loads: wstrb = 0000.
- BUSY holds the bus outputs constant until dmem_ack.
- On ack:
  - Drop dmem_req and return to IDLE.
  - Load: rdata is shifted right by 8·addr[1:0], then masked to the access size, then sign-extended when loadsign=1 (zero-extended otherwise).
  - wb_data = seldmresult_in ? extracted data : ans_ex. wb_valid = !dm_rw_in.
  - Store: wb_valid=0.
- stall = (IDLE & dm_en_in & aligned) | (BUSY & !dmem_ack & !timeout). Combinational.
- wb_valid=0 on every cycle the stage is not completing an operation (bubble).
- Address and data for the outstanding access come from the latched copy, never from the live inputs.

## Timing
- Reset values: state IDLE; dmem_req, dmem_we, wb_valid, misalign and mem_fault = 0; dmem_addr, dmem_wdata, dmem_wstrb, wb_data and wb_rw = 0.
- Non-memory op: 1-cycle latency, never stalls.
- Memory op: request is visible 1 cycle after acceptance. Result is registered on the ack edge.
- Minimum memory latency is 2 cycles, with ack in the first BUSY cycle. stall is high for the accept cycle plus every non-ack BUSY cycle.
- In the ack cycle stall=0, so upstream advances on the same edge; the next op is evaluated in IDLE. This gives back-to-back memory ops with no extra bubble.
- An ack seen in IDLE is ignored.
- Reset asserted mid-transaction: dmem_req drops immediately, state goes to IDLE, and a later ack is ignored.
- misalign and mem_fault pulse for exactly 1 cycle, registered.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: drop dmem_req, go to IDLE, pulse mem_fault, wb_valid=0, stall=0 in that cycle.
  - An ack arriving in the same cycle as the timeout wins.
- MEM_TIMEOUT_EN undefined: BUSY waits indefinitely; mem_fault is tied to 0 and the counter is absent.

## Test plan
- ALU op ans_ex=0x1234, rw_in=5, dm_en_in=0 -> next cycle wb_data=0x1234, wb_rw=5, wb_valid=1, stall never high.
- Signed byte load at 0x103 with enloadsize=00, loadsign=1, rdata=0x80FF0000, ack 3 cycles after req -> dmem_addr=0x100, wstrb=0000, stall high for 3 cycles, wb_data=0xFFFFFF80.
- Halfword store at 0x202 with B=0x0000BEEF -> dmem_we=1, wstrb=1100, wdata=0xBEEFBEEF, wb_valid=0.
- Word load at 0x301 -> misalign pulses once, dmem_req stays 0, stall stays 0.
- Reset pulled low during BUSY, then ack arrives after release -> dmem_req=0 immediately, state IDLE, no wb_valid.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> mem_fault pulses after 4 BUSY cycles, stall drops, dmem_req=0. Repeat with ack on the 4th cycle -> normal completion, no fault.

Source files
------------

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - memory access pipeline stage: req/ack data-memory bus, load align/extend, writeback register
// Optional feature: define MEM_TIMEOUT_EN to abort bus transactions that see no ack within TIMEOUT_CYCLES BUSY cycles.
module memory_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ans_ex,
  input  logic [31:0] B_Bypass,
  input  logic        dm_en_in,
  input  logic        dm_rw_in,
  input  logic        seldmresult_in,
  input  logic [4:0]  rw_in,
  input  logic [1:0]  enloadsize,
  input  logic        loadsign,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rw,
  output logic        wb_valid,
  output logic        misalign,
  output logic        mem_fault
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Elaboration-time guard on the timeout range (8-bit counter, at least two BUSY cycles).
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 2..255");
  end

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rw_q, wb_rw_d;
  logic        wb_valid_q, wb_valid_d;
  logic        misalign_q, misalign_d;

  // Latched copy of the accepted request; the live inputs are never used while BUSY.
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic        sel_q, sel_d;
  logic        lrw_q, lrw_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] ans_q, ans_d;

  logic        is_word, is_half, aligned, accept, timeout_w;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign is_word = enloadsize[1];
  assign is_half = !enloadsize[1] && enloadsize[0];
  assign aligned = is_word ? (ans_ex[1:0] == 2'b00) :
                   is_half ? !ans_ex[0] : 1'b1;
  assign accept  = (state_q == IDLE) && dm_en_in && aligned;
  assign stall   = accept || ((state_q == BUSY) && !dmem_ack && !timeout_w);

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       fault_q, fault_d;

  // The Nth ack-less BUSY cycle (counter holds N-1) aborts; an ack in that cycle wins.
  assign timeout_w = (state_q == BUSY) && !dmem_ack && (cnt_q == TO_LAST);
  assign mem_fault = fault_q;

  // Counter clears when a request is accepted and advances on every ack-less BUSY cycle.
  always_comb begin
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    if (accept) begin
      cnt_d = 8'd0;
    end else if (state_q == BUSY && !dmem_ack) begin
      if (timeout_w) fault_d = 1'b1;
      else           cnt_d = cnt_q + 8'd1;
    end
  end

  // Timeout counter and fault pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
`else
  assign timeout_w = 1'b0;
  assign mem_fault = 1'b0;
`endif

  // Store strobes and lane-replicated data for the live request; loads drive no strobes.
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = B_Bypass;
    if (is_word) begin
      st_wstrb = 4'b1111;
      st_wdata = B_Bypass;
    end else if (is_half) begin
      st_wstrb = 4'b0011 << ans_ex[1:0];
      st_wdata = {2{B_Bypass[15:0]}};
    end else begin
      st_wstrb = 4'b0001 << ans_ex[1:0];
      st_wdata = {4{B_Bypass[7:0]}};
    end
    if (!dm_rw_in) st_wstrb = 4'b0000;
  end

  assign shifted = dmem_rdata >> {off_q, 3'b000};

  // Load extraction: lane shift, size mask, then sign or zero extension from latched controls.
  always_comb begin
    load_data = shifted;
    if (size_q[1]) begin
      load_data = shifted;
    end else if (size_q[0]) begin
      load_data = {{16{shifted[15] & sign_q}}, shifted[15:0]};
    end else begin
      load_data = {{24{shifted[7] & sign_q}}, shifted[7:0]};
    end
  end

  // Next-state and registered-output logic for the IDLE/BUSY controller.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wb_data_d  = wb_data_q;
    wb_rw_d    = wb_rw_q;
    wb_valid_d = 1'b0;
    misalign_d = 1'b0;
    off_d      = off_q;
    size_d     = size_q;
    sign_d     = sign_q;
    sel_d      = sel_q;
    lrw_d      = lrw_q;
    rd_d       = rd_q;
    ans_d      = ans_q;
    case (state_q)
      IDLE: begin
        if (!dm_en_in) begin
          wb_data_d  = ans_ex;
          wb_rw_d    = rw_in;
          wb_valid_d = 1'b1;
        end else if (!aligned) begin
          misalign_d = 1'b1;
        end else begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = dm_rw_in;
          addr_d  = {ans_ex[31:2], 2'b00};
          wdata_d = st_wdata;
          wstrb_d = st_wstrb;
          off_d   = ans_ex[1:0];
          size_d  = enloadsize;
          sign_d  = loadsign;
          sel_d   = seldmresult_in;
          lrw_d   = dm_rw_in;
          rd_d    = rw_in;
          ans_d   = ans_ex;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!lrw_q) begin
            wb_data_d  = sel_q ? load_data : ans_q;
            wb_rw_d    = rd_q;
            wb_valid_d = 1'b1;
          end
        end else if (timeout_w) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, bus, writeback and latched-request registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      wb_data_q  <= 32'd0;
      wb_rw_q    <= 5'd0;
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      off_q      <= 2'd0;
      size_q     <= 2'd0;
      sign_q     <= 1'b0;
      sel_q      <= 1'b0;
      lrw_q      <= 1'b0;
      rd_q       <= 5'd0;
      ans_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wb_data_q  <= wb_data_d;
      wb_rw_q    <= wb_rw_d;
      wb_valid_q <= wb_valid_d;
      misalign_q <= misalign_d;
      off_q      <= off_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      sel_q      <= sel_d;
      lrw_q      <= lrw_d;
      rd_q       <= rd_d;
      ans_q      <= ans_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;
  assign wb_data    = wb_data_q;
  assign wb_rw      = wb_rw_q;
  assign wb_valid   = wb_valid_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - directed self-checking bench for memory_access_stage
module tb_memory_access_stage;

  logic        clk;
  logic        reset;
  logic [31:0] ans_ex;
  logic [31:0] B_Bypass;
  logic        dm_en_in;
  logic        dm_rw_in;
  logic        seldmresult_in;
  logic [4:0]  rw_in;
  logic [1:0]  enloadsize;
  logic        loadsign;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] wb_data;
  logic [4:0]  wb_rw;
  logic        wb_valid;
  logic        misalign;
  logic        mem_fault;

  int checks = 0;
  int errors = 0;

  memory_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .ans_ex(ans_ex), .B_Bypass(B_Bypass),
    .dm_en_in(dm_en_in), .dm_rw_in(dm_rw_in), .seldmresult_in(seldmresult_in),
    .rw_in(rw_in), .enloadsize(enloadsize), .loadsign(loadsign), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_data(wb_data), .wb_rw(wb_rw),
    .wb_valid(wb_valid), .misalign(misalign), .mem_fault(mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; ans_ex = 32'd0; B_Bypass = 32'd0; dm_en_in = 1'b0; dm_rw_in = 1'b0;
    seldmresult_in = 1'b0; rw_in = 5'd0; enloadsize = 2'b00; loadsign = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;

    @(negedge clk);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_we", {31'd0, dmem_we}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rw", {27'd0, wb_rw}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_mem_fault", {31'd0, mem_fault}, 32'd0);
    reset = 1'b1;

    // ALU pass-through
    ans_ex = 32'h1234; rw_in = 5'd5; dm_en_in = 1'b0;
    #1 check("alu_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    check("alu_wb_data", wb_data, 32'h1234);
    check("alu_wb_rw", {27'd0, wb_rw}, 32'd5);
    check("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("alu_stall2", {31'd0, stall}, 32'd0);

    // ack while IDLE is ignored
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF; ans_ex = 32'h77; rw_in = 5'd6;
    @(negedge clk);
    check("idle_ack_req", {31'd0, dmem_req}, 32'd0);
    check("idle_ack_wb", wb_data, 32'h77);
    dmem_ack = 1'b0;

    // signed byte load at 0x103, ack in the third BUSY cycle
    ans_ex = 32'h103; dm_en_in = 1'b1; dm_rw_in = 1'b0; enloadsize = 2'b00;
    loadsign = 1'b1; seldmresult_in = 1'b1; rw_in = 5'd7;
    #1 check("lb_stall_acc", {31'd0, stall}, 32'd1);
    @(negedge clk);
    check("lb_req", {31'd0, dmem_req}, 32'd1);
    check("lb_addr", dmem_addr, 32'h100);
    check("lb_wstrb", {28'd0, dmem_wstrb}, 32'd0);
    check("lb_we", {31'd0, dmem_we}, 32'd0);
    check("lb_stall_b1", {31'd0, stall}, 32'd1);
    check("lb_wb_valid_b1", {31'd0, wb_valid}, 32'd0);
    ans_ex = 32'hDEAD_0000; rw_in = 5'd9;
    @(negedge clk);
    check("lb_stall_b2", {31'd0, stall}, 32'd1);
    check("lb_addr_held", dmem_addr, 32'h100);
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_0000;
    #1 check("lb_stall_ack", {31'd0, stall}, 32'd0);
    @(negedge clk);
    dmem_ack = 1'b0;
    check("lb_wb_data", wb_data, 32'hFFFF_FF80);
    check("lb_wb_rw", {27'd0, wb_rw}, 32'd7);
    check("lb_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("lb_req_drop", {31'd0, dmem_req}, 32'd0);

    // halfword store at 0x202
    ans_ex = 32'h202; B_Bypass = 32'h0000_BEEF; enloadsize = 2'b01; dm_rw_in = 1'b1; rw_in = 5'd3;
    #1 check("sh_stall_acc", {31'd0, stall}, 32'd1);
    @(negedge clk);
    check("sh_we", {31'd0, dmem_we}, 32'd1);
    check("sh_wstrb", {28'd0, dmem_wstrb}, 32'hC);
    check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    check("sh_addr", dmem_addr, 32'h200);
    dmem_ack = 1'b1;
    #1 check("sh_stall_ack", {31'd0, stall}, 32'd0);
    @(negedge clk);
    dmem_ack = 1'b0;
    check("sh_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("sh_req_drop", {31'd0, dmem_req}, 32'd0);

    // unsigned halfword load at 0x102, issued right after the ack cycle
    ans_ex = 32'h102; dm_rw_in = 1'b0; loadsign = 1'b0; rw_in = 5'd4;
    @(negedge clk);
    check("lhu_req", {31'd0, dmem_req}, 32'd1);
    check("lhu_addr", dmem_addr, 32'h100);
    dmem_ack = 1'b1; dmem_rdata = 32'h8001_1234;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("lhu_wb_data", wb_data, 32'h0000_8001);
    check("lhu_wb_rw", {27'd0, wb_rw}, 32'd4);
    check("lhu_wb_valid", {31'd0, wb_valid}, 32'd1);

    // byte store at 0x101
    ans_ex = 32'h101; B_Bypass = 32'h0000_00A5; enloadsize = 2'b00; dm_rw_in = 1'b1;
    @(negedge clk);
    check("sb_wstrb", {28'd0, dmem_wstrb}, 32'h2);
    check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("sb_wb_valid", {31'd0, wb_valid}, 32'd0);

    // word load with writeback of the (latched) address
    ans_ex = 32'h300; enloadsize = 2'b10; dm_rw_in = 1'b0; seldmresult_in = 1'b0; rw_in = 5'd11;
    @(negedge clk);
    check("lw_wstrb", {28'd0, dmem_wstrb}, 32'd0);
    ans_ex = 32'h999; rw_in = 5'd1; dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("lw_wb_data", wb_data, 32'h300);
    check("lw_wb_rw", {27'd0, wb_rw}, 32'd11);

    // misaligned word load at 0x301
    ans_ex = 32'h301; enloadsize = 2'b10; seldmresult_in = 1'b1;
    #1 check("mis_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    check("mis_pulse", {31'd0, misalign}, 32'd1);
    check("mis_req", {31'd0, dmem_req}, 32'd0);
    check("mis_wb_valid", {31'd0, wb_valid}, 32'd0);
    // misaligned halfword store at 0x203
    ans_ex = 32'h203; enloadsize = 2'b01; dm_rw_in = 1'b1;
    @(negedge clk);
    check("mis_half", {31'd0, misalign}, 32'd1);
    dm_en_in = 1'b0; dm_rw_in = 1'b0; ans_ex = 32'h42; rw_in = 5'd2;
    @(negedge clk);
    check("mis_clear", {31'd0, misalign}, 32'd0);
    check("mis_alu_wb", wb_data, 32'h42);
    check("mis_alu_valid", {31'd0, wb_valid}, 32'd1);

    // reset asserted during BUSY, ack after release
    ans_ex = 32'h10; dm_en_in = 1'b1; enloadsize = 2'b00; rw_in = 5'd8;
    @(negedge clk);
    check("rb_req", {31'd0, dmem_req}, 32'd1);
    reset = 1'b0; dm_en_in = 1'b0; ans_ex = 32'h55; rw_in = 5'd2;
    #1;
    check("rb_req_drop", {31'd0, dmem_req}, 32'd0);
    check("rb_stall", {31'd0, stall}, 32'd0);
    check("rb_wb_valid", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("rb_req_after", {31'd0, dmem_req}, 32'd0);
    check("rb_wb_data", wb_data, 32'h55);
    check("rb_wb_rw", {27'd0, wb_rw}, 32'd2);

`ifdef MEM_TIMEOUT_EN
    // timeout after 4 ack-less BUSY cycles
    ans_ex = 32'h400; dm_en_in = 1'b1; enloadsize = 2'b10; seldmresult_in = 1'b1; rw_in = 5'd12;
    @(negedge clk);
    check("to_b1_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    check("to_b2_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    check("to_b3_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    check("to_b4_stall", {31'd0, stall}, 32'd0);
    check("to_b4_fault", {31'd0, mem_fault}, 32'd0);
    dm_en_in = 1'b0; ans_ex = 32'h66; rw_in = 5'd3;
    @(negedge clk);
    check("to_fault", {31'd0, mem_fault}, 32'd1);
    check("to_req", {31'd0, dmem_req}, 32'd0);
    check("to_wb_valid", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    check("to_fault_clr", {31'd0, mem_fault}, 32'd0);
    check("to_alu_valid", {31'd0, wb_valid}, 32'd1);

    // ack in the 4th BUSY cycle wins over the timeout
    ans_ex = 32'h400; dm_en_in = 1'b1; rw_in = 5'd12;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h1122_3344;
    #1 check("ta_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    dmem_ack = 1'b0; dm_en_in = 1'b0;
    check("ta_fault", {31'd0, mem_fault}, 32'd0);
    check("ta_wb_data", wb_data, 32'h1122_3344);
    check("ta_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("ta_req", {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    check("ta_fault2", {31'd0, mem_fault}, 32'd0);
`else
    check("no_fault", {31'd0, mem_fault}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
